// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC cosine custom-instruction front end.
// Holds the controller state encoding, the float32 constants returned for
// operands resolved locally, the exponent limit of the core's convergence
// range and the default core latency.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ci_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Biased exponent at and above which |x| >= 2.0: outside Q1.20 and the
  // CORDIC convergence range.
  localparam logic [7:0] EXP_RANGE_LIMIT = 8'h80;
  localparam logic [7:0] EXP_ALL_ONES    = 8'hFF;
  localparam logic [7:0] EXP_ZERO        = 8'h00;

  localparam int CORE_LATENCY_DEFAULT = 6;
  localparam int CNT_W                = 4;

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational screen for float32 cosine operands.
//   operand        : float32 angle in radians
//   is_special     : high when the operand is resolved without the core
//   special_result : float32 result for special operands (0 otherwise)
// Inf/NaN and |x| >= 2.0 give a quiet NaN; zero and subnormals give 1.0
// (cos of a value this small rounds to exactly 1.0 in single precision).
module fp_operand_classify
  import cordic_pkg::*;
(
  input  logic [31:0] operand,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic [7:0] exp_f;
  logic       unused_bits;

  assign exp_f = operand[30:23];
  // Sign and mantissa never affect the classification.
  assign unused_bits = ^{operand[31], operand[22:0]};

  always_comb begin
    is_special     = 1'b1;
    special_result = FP_QNAN;
    if (exp_f == EXP_ALL_ONES) begin
      special_result = FP_QNAN;
    end else if (exp_f >= EXP_RANGE_LIMIT) begin
      special_result = FP_QNAN;
    end else if (exp_f == EXP_ZERO) begin
      special_result = FP_ONE;
    end else begin
      is_special     = 1'b0;
      special_result = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/cordic_ci_ctrl.sv
// Multicycle custom-instruction front end for the CORDIC cosine core.
//   clk, reset     : single clock, synchronous active-high reset (wins over clk_en)
//   clk_en         : when low every register holds
//   start, dataa   : request handshake and float32 angle
//   done, result   : one-cycle completion strobe and registered float32 cos
//   core_float_in  : registered operand to the external core
//   core_float_out : core result, settled CORE_LATENCY edges after an operand change
// Special operands finish locally one cycle after accept; normal operands are
// held on core_float_in and the core output is captured after CORE_LATENCY
// enabled cycles.
module cordic_ci_ctrl
  import cordic_pkg::*;
#(
  parameter int CORE_LATENCY = CORE_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] core_float_in,
  input  logic [31:0] core_float_out
);

  localparam logic [CNT_W-1:0] CNT_INIT = CORE_LATENCY[CNT_W-1:0];

  ci_state_t        state_q;
  ci_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;

  logic        is_special;
  logic [31:0] special_result;

  logic accept_special;
  logic accept_normal;
  logic capture;

  fp_operand_classify u_classify (
    .operand        (dataa),
    .is_special     (is_special),
    .special_result (special_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = is_special ? ST_FIN : ST_RUN;
      ST_RUN:  if (cnt_q == 4'd1) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done           = (state_q == ST_FIN);
    accept_special = clk_en && start && (state_q == ST_IDLE) && is_special;
    accept_normal  = clk_en && start && (state_q == ST_IDLE) && !is_special;
    capture        = clk_en && (state_q == ST_RUN) && (cnt_q == 4'd1);
  end

  // core_float_in moves only on a normal accept, so the core output stays
  // settled through any clk_en stall before capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      result        <= 32'h0000_0000;
      core_float_in <= 32'h0000_0000;
      cnt_q         <= '0;
    end else if (clk_en) begin
      if (accept_normal) begin
        core_float_in <= dataa;
        cnt_q         <= CNT_INIT;
      end else if (state_q == ST_RUN) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (accept_special) begin
        result <= special_result;
      end else if (capture) begin
        result <= core_float_out;
      end
    end
  end

endmodule
